toggle_hs_rx: RTL and testbench
===============================

TOGGLE_HS_RX -- requirements
Module: toggle_hs_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of receive buffer entries; the value SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the req_tgl synchronizer; the value SHALL be at least 2.
REQ-004 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset; the block SHALL be in reset while reset=0.
REQ-006 Port req_tgl  input  1  request toggle from the initiator, asynchronous to clk; each level change is one transfer.
REQ-007 Port req_data  input  DATA_W  payload; it is stable from the req_tgl change until the matching ack_tgl change.
REQ-008 Port ack_tgl  output  1  acknowledge toggle to the initiator; each level change acknowledges one transfer.
REQ-009 Port out_data  output  DATA_W  head-of-buffer payload.
REQ-010 Port out_valid  output  1  high when the buffer is non-empty.
REQ-011 Port out_ready  input  1  consumer accepts out_data on a clock edge where out_valid=1 and out_ready=1.
REQ-012 Port level  output  $clog2(DEPTH+1)  current buffer occupancy.
REQ-013 Port stall  output  1  high while a request is pending and the buffer cannot accept it.

Function
REQ-014 req_tgl SHALL pass through a SYNC_STAGES flop chain; only the last stage (req_s) SHALL be used by other logic.
REQ-015 A register req_seen SHALL hold the last accepted request level, and pending SHALL equal req_s XOR req_seen.
REQ-016 The FSM SHALL have exactly two states: IDLE and STALL.
REQ-017 In IDLE, a capture SHALL occur when pending=1 and can_push=1, with can_push = (level<DEPTH) OR (out_valid AND out_ready).
REQ-018 In IDLE, when pending=1 and can_push=0, the FSM SHALL go to STALL with no capture.
REQ-019 In STALL, the FSM SHALL capture and return to IDLE on the first edge where can_push=1, and SHALL otherwise remain in STALL; stall SHALL be 1 exactly while the state is STALL.
REQ-020 On a capture, on the same edge: req_data SHALL be written to the buffer tail; req_seen SHALL take the value of req_s; ack_tgl SHALL invert.
REQ-021 ack_tgl SHALL change only on a capture; exactly one ack_tgl change SHALL occur per req_tgl change.
REQ-022 Latency: if req_tgl changes before edge E0, the capture and the ack_tgl change SHALL occur at edge E0+SYNC_STAGES when the buffer is not full; out_valid SHALL be 1 after that edge.
REQ-023 The buffer SHALL be a FIFO; out_data SHALL show the oldest entry whenever out_valid=1, with no read latency.
REQ-024 A push and a pop on the same edge SHALL leave level unchanged, including when level=DEPTH.
REQ-025 A pop when out_valid=0 SHALL be ignored; level SHALL never exceed DEPTH or go below 0.
REQ-026 The read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-027 A second req_tgl change before the ack_tgl change is a protocol violation; its behaviour is undefined and the verification bench SHALL not drive it.

Reset
REQ-028 While reset=0: ack_tgl=0, out_valid=0, level=0, stall=0, FSM=IDLE, pointers=0, req_seen=0, and all synchronizer stages=0.
REQ-029 out_data SHALL be 0 during reset; buffer contents need not be cleared.
REQ-030 A reset asserted mid-transfer SHALL discard the pending request and all buffered data; after reset release, an initiator req_tgl level of 1 SHALL be seen as a new request.

Structure
REQ-031 A package toggle_hs_pkg SHALL define the FSM state enum (IDLE, STALL) and the default DATA_W, DEPTH and SYNC_STAGES values.
REQ-032 The FIFO SHALL be a sub-module toggle_rx_fifo (parameters DATA_W and DEPTH; push, pop, data, level, and empty/full flags).
REQ-033 The synchronizer, req_seen, the FSM and ack_tgl SHALL reside in toggle_hs_rx.

Verification
REQ-034 Single transfer: req_data=0xA5, toggle req_tgl, out_ready=1 -> ack_tgl toggles 2 edges later, out_valid=1 with out_data=0xA5 for one cycle, then level=0.
REQ-035 Fill: out_ready=0, 5 transfers 0x01..0x05 with DEPTH=4 -> 4 acks, level=4, stall=1, no fifth ack; pulse out_ready for one cycle -> 0x01 popped, fifth ack on the same edge, level stays 4.
REQ-036 Drain order: after the fill case, out_ready=1 -> out_data 0x02,0x03,0x04,0x05 in order, then out_valid=0.
REQ-037 Wrap-around: 10 back-to-back transfers 0x10..0x19 with random out_ready -> all 10 delivered in order, one ack per request.
REQ-038 Reset mid-operation: level=3 and stall=0, drive reset=0 -> all outputs take their REQ-028 values immediately, without a clock edge.
REQ-039 Reset release with the initiator req_tgl level at 1 -> exactly one capture and ack_tgl=1 at edge SYNC_STAGES after release.

Source files
------------

// File: rtl/toggle_hs_pkg.sv
// Shared types and default parameters for the toggle-handshake receiver.
package toggle_hs_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } rx_state_e;

endpackage

// File: rtl/toggle_rx_fifo.sv
// Receive buffer: power-of-two FIFO with a combinational head and an occupancy count.
module toggle_rx_fifo
    import toggle_hs_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    // A push into a full buffer is only legal when a pop frees the head on the same edge.
    always_comb begin
        do_pop   = pop && (level_q != '0);
        do_push  = push && ((level_q != LVL_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
        else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign level    = level_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/toggle_hs_rx.sv
// Toggle-handshake receiver: synchronizes req_tgl, captures payloads into a FIFO,
// and acknowledges each capture with an ack_tgl level change.
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int DEPTH       = DEF_DEPTH,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic              stall
);

    rx_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    logic                   req_s, pending, can_push, capture;
    logic                   fifo_empty, fifo_full;

    assign req_s = sync_q[SYNC_STAGES-1];

    // A freed head slot on this edge counts as room, so a full buffer can still capture.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], req_tgl};
        pending  = req_s ^ req_seen_q;
        can_push = !fifo_full || (!fifo_empty && out_ready);
        state_d  = state_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    if (can_push) capture = 1'b1;
                    else          state_d = STALL;
                end
            end
            STALL: begin
                if (can_push) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        req_seen_d = capture ? req_s : req_seen_q;
        ack_d      = capture ? ~ack_q : ack_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
        end
    end

    toggle_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (capture),
        .push_data (req_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .level     (level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ack_tgl   = ack_q;
    assign out_valid = !fifo_empty;
    assign stall     = (state_q == STALL);

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed self-checking bench for toggle_hs_rx with default parameters
// (DATA_W=8, DEPTH=4, SYNC_STAGES=2).
module tb_toggle_hs_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_tgl = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       ack_tgl;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic       stall;

    int   tests_run = 0;
    int   tests_failed = 0;
    logic exp_ack = 1'b0;

    toggle_hs_rx #(
        .DATA_W      (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .ack_tgl   (ack_tgl),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Sample and drive 1 time unit after each rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Start a transfer and wait (bounded) for its acknowledge.
    task automatic send_wait(input logic [7:0] d, input string name);
        logic got;
        req_data = d;
        req_tgl  = ~req_tgl;
        exp_ack  = ~exp_ack;
        got      = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            step();
            if (ack_tgl === exp_ack) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL %s: ack_tgl got %b want %b", name, ack_tgl, exp_ack);
        end
    endtask

    task automatic test_reset;
        #3;
        tests_run++;
        if ({ack_tgl, out_valid, level, stall, out_data} !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: ack=%b valid=%b level=%0d stall=%b data=%h want all 0",
                     ack_tgl, out_valid, level, stall, out_data);
        end
        step();
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if ({ack_tgl, out_valid, level, stall} !== 6'h0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: ack=%b valid=%b level=%0d stall=%b want 0",
                     ack_tgl, out_valid, level, stall);
        end
    endtask

    task automatic test_single;
        req_data  = 8'hA5;
        out_ready = 1'b1;
        req_tgl   = ~req_tgl;
        step();
        step();
        tests_run++;
        if (ack_tgl !== exp_ack || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_early: ack=%b valid=%b want %b 0", ack_tgl, out_valid, exp_ack);
        end
        step();
        exp_ack = ~exp_ack;
        tests_run++;
        if (ack_tgl !== exp_ack || out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_capture: ack=%b valid=%b data=%h level=%0d want %b 1 a5 1",
                     ack_tgl, out_valid, out_data, level, exp_ack);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_pop: valid=%b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_wait(8'(i), "fill_ack");
        tests_run++;
        if (level !== 3'd4 || out_data !== 8'h01 || stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_level: level=%0d data=%h stall=%b want 4 01 0", level, out_data, stall);
        end
        req_data = 8'h05;
        req_tgl  = ~req_tgl;
        repeat (6) step();
        tests_run++;
        if (ack_tgl !== exp_ack || stall !== 1'b1 || level !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL fill_stall: ack=%b stall=%b level=%0d want %b 1 4", ack_tgl, stall, level, exp_ack);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_ack   = ~exp_ack;
        tests_run++;
        if (ack_tgl !== exp_ack || level !== 3'd4 || out_data !== 8'h02 || stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_pushpop: ack=%b level=%0d data=%h stall=%b want %b 4 02 0",
                     ack_tgl, level, out_data, stall, exp_ack);
        end
    endtask

    task automatic test_drain;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
                tests_failed++;
                $display("[TB] FAIL drain_order: valid=%b data=%h want 1 %h", out_valid, out_data, 8'(k));
            end
            step();
        end
        tests_run++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL drain_empty: valid=%b level=%0d want 0 0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int   tx = 0;
        int   rx = 0;
        int   acks = 0;
        logic busy = 1'b0;
        logic last_ack;
        last_ack = ack_tgl;
        for (int cyc = 0; cyc < 400 && rx < 10; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_data !== 8'(8'h10 + rx)) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_data: got %h want %h", out_data, 8'(8'h10 + rx));
                end
                rx++;
            end
            if (ack_tgl !== last_ack) begin
                acks++;
                last_ack = ack_tgl;
                if (busy) begin
                    busy = 1'b0;
                    tx++;
                end
            end
            if (!busy && tx < 10) begin
                req_data = 8'(8'h10 + tx);
                req_tgl  = ~req_tgl;
                busy     = 1'b1;
            end
            step();
        end
        out_ready = 1'b0;
        tests_run++;
        if (rx != 10 || acks != 10 || ack_tgl !== exp_ack) begin
            tests_failed++;
            $display("[TB] FAIL wrap_counts: delivered=%0d acks=%0d ack=%b want 10 10 %b", rx, acks, ack_tgl, exp_ack);
        end
        tests_run++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_empty: level=%0d valid=%b want 0 0", level, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send_wait(8'h31, "mid_ack");
        send_wait(8'h32, "mid_ack");
        send_wait(8'h33, "mid_ack");
        tests_run++;
        if (level !== 3'd3 || stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_level: level=%0d stall=%b want 3 0", level, stall);
        end
        req_data = 8'h77;
        req_tgl  = ~req_tgl;
        step();
        reset = 1'b0;
        #1;
        exp_ack = 1'b0;
        tests_run++;
        if ({ack_tgl, out_valid, level, stall, out_data} !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: ack=%b valid=%b level=%0d stall=%b data=%h want all 0",
                     ack_tgl, out_valid, level, stall, out_data);
        end
    endtask

    task automatic test_reset_release;
        req_tgl  = 1'b1;
        req_data = 8'h3C;
        step();
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if (ack_tgl !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL release_early: ack=%b valid=%b want 0 0", ack_tgl, out_valid);
        end
        step();
        step();
        tests_run++;
        if (ack_tgl !== 1'b1 || level !== 3'd1 || out_valid !== 1'b1 || out_data !== 8'h3C) begin
            tests_failed++;
            $display("[TB] FAIL release_capture: ack=%b level=%0d valid=%b data=%h want 1 1 1 3c",
                     ack_tgl, level, out_valid, out_data);
        end
        repeat (5) step();
        tests_run++;
        if (ack_tgl !== 1'b1 || level !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL release_single: ack=%b level=%0d want 1 1", ack_tgl, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_reset_release();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
